// File: rtl/mdu_param.sv
// -----------------------------------------------------------------------------
// mdu_param -- multi-cycle multiply/divide unit with HI/LO result registers.
//
// Multiplies and divides run for a fixed, parameterised number of busy cycles;
// HI/LO only change at the edge that ends the last busy cycle, and a one-cycle
// done pulse marks the first cycle the new results are visible. MTHI/MTLO write
// HI/LO directly from A when the unit is idle.
//
// Ports
//   clk    in   1      clock, all state updates on the rising edge
//   reset  in   1      synchronous active-high reset
//   start  in   1      begin operation op (accepted only when idle)
//   op     in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A      in   WIDTH  first operand (rs); source for MTHI/MTLO
//   B      in   WIDTH  second operand (rt)
//   busy   out  1      multiply/divide in progress
//   done   out  1      one-cycle pulse when new mul/div results appear
//   hi     out  WIDTH  HI register
//   lo     out  WIDTH  LO register
// -----------------------------------------------------------------------------
module mdu_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  // The counter holds "busy cycles remaining after this one", so LAT-1 at most.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             capture;

  // Captured operands for the operation in flight.
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;

  // ---------------------------------------------------------------------------
  // Datapath: results are formed from the captured operands and only written
  // into HI/LO on the final busy cycle.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, div_b, uq, ur, quot, rem;

  always_comb begin
    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of an unsigned
    // multiply of the extended values are then the correct product either way.
    a_ext   = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = a_ext * b_ext;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // follows the dividend. Most-negative / -1 wraps back to most-negative.
    a_neg  = signed_q & a_q[WIDTH-1];
    b_neg  = signed_q & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_zero = (b_q == '0);
    div_b  = b_zero ? WIDTH'(1) : b_mag;  // keeps the divider defined; result discarded
    uq     = a_mag / div_b;
    ur     = a_mag % div_b;
    quot   = (a_neg ^ b_neg) ? -uq : uq;
    rem    = a_neg ? -ur : ur;
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // statement leaves one unassigned, which would infer a latch.
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    hi_n    = hi;
    lo_n    = lo;
    capture = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              state_n = MUL;
              cnt_n   = MUL_LOAD;
              capture = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_n = DIV;
              cnt_n   = DIV_LOAD;
              capture = 1'b1;
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            default: ;  // reserved op codes do nothing
          endcase
        end
      end
      MUL: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
          hi_n    = product[2*WIDTH-1:WIDTH];
          lo_n    = product[WIDTH-1:0];
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DIV: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
          if (!b_zero) begin
            hi_n = rem;
            lo_n = quot;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Control and result registers; outputs come straight from these flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  // NOTE: operand registers are deliberately not reset: they are always
  // loaded before being used, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (capture) begin
      a_q      <= A;
      b_q      <= B;
      signed_q <= ~op[0];  // MULT/DIV are even codes, MULTU/DIVU odd
    end
  end

endmodule

// File: tb/tb_mdu_param.sv
// -----------------------------------------------------------------------------
// tb_mdu_param -- self-checking bench for mdu_param (WIDTH=32, MUL_LAT=5,
// DIV_LAT=10). An operation-level model tracks HI/LO, busy and done; a single
// compare process checks the DUT against it every cycle, and directed tests add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mdu_param;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  mdu_param #(.WIDTH(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a_in),
    .B     (b_in),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: an accepted mul/div computes its result immediately and
  // holds it until the busy period runs out.
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] m_pend_hi, m_pend_lo;
  bit           m_pend_wr;
  int           m_left = 0;
  bit           m_done = 0;

  always @(posedge clk) begin
    longint       sa, sb, sp;
    logic [63:0]  up;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          if (m_pend_wr) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
          end
        end
      end else if (start) begin
        sa = longint'($signed(a_in));
        sb = longint'($signed(b_in));
        m_pend_wr = 1;
        case (op)
          3'd0: begin sp = sa * sb; m_pend_hi = sp[63:32]; m_pend_lo = sp[31:0]; m_left = MUL_LAT; end
          3'd1: begin up = {32'b0, a_in} * {32'b0, b_in};
                      m_pend_hi = up[63:32]; m_pend_lo = up[31:0]; m_left = MUL_LAT; end
          3'd2: begin
            m_left = DIV_LAT;
            if (b_in == 0) m_pend_wr = 0;
            else begin
              sp = sa / sb; m_pend_lo = sp[31:0];
              sp = sa % sb; m_pend_hi = sp[31:0];
            end
          end
          3'd3: begin
            m_left = DIV_LAT;
            if (b_in == 0) m_pend_wr = 0;
            else begin m_pend_lo = a_in / b_in; m_pend_hi = a_in % b_in; end
          end
          3'd4: m_hi = a_in;
          3'd5: m_lo = a_in;
          default: ;
        endcase
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'b0, busy}, {63'b0, (m_left > 0)});
      check("done", {63'b0, done}, {63'b0, m_done});
      check("hi",   {32'b0, hi}, {32'b0, m_hi});
      check("lo",   {32'b0, lo}, {32'b0, m_lo});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge).
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; op = 3'd7; a_in = '0; b_in = '0;
  endtask

  // Waits (bounded) for done, counting busy cycles seen on the way.
  task automatic wait_done(input string name, input int exp_busy);
    int n = 0;
    int bc = 0;
    while (!done && n < 60) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, {63'b0, done}, 64'd1);
    check({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
  endtask

  initial begin
    int dcount;
    reset = 1'b1; start = 1'b0; op = 3'd7; a_in = '0; b_in = '0;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_hi", {32'b0, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);

    // MULT -1 * 3
    issue(3'd0, 32'hFFFFFFFF, 32'd3);
    wait_done("mult", MUL_LAT);
    check("mult_hi", {32'b0, hi}, 64'hFFFFFFFF);
    check("mult_lo", {32'b0, lo}, 64'hFFFFFFFD);
    @(negedge clk);

    // MULTU same operands
    issue(3'd1, 32'hFFFFFFFF, 32'd3);
    wait_done("multu", MUL_LAT);
    check("multu_hi", {32'b0, hi}, 64'h2);
    check("multu_lo", {32'b0, lo}, 64'hFFFFFFFD);

    // DIV -7 / 2, then DIVU 7 / 2
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done("div", DIV_LAT);
    check("div_lo", {32'b0, lo}, 64'hFFFFFFFD);
    check("div_hi", {32'b0, hi}, 64'hFFFFFFFF);
    issue(3'd3, 32'd7, 32'd2);
    wait_done("divu", DIV_LAT);
    check("divu_lo", {32'b0, lo}, 64'd3);
    check("divu_hi", {32'b0, hi}, 64'd1);

    // MTHI / MTLO, then DIVU by zero leaves them untouched
    issue(3'd4, 32'h11, 32'd0);
    check("mthi_hi", {32'b0, hi}, 64'h11);
    check("mthi_busy", {63'b0, busy}, 64'd0);
    issue(3'd5, 32'h22, 32'd0);
    check("mtlo_lo", {32'b0, lo}, 64'h22);
    check("mtlo_done", {63'b0, done}, 64'd0);
    issue(3'd3, 32'd9, 32'd0);
    wait_done("div0", DIV_LAT);
    check("div0_hi", {32'b0, hi}, 64'h11);
    check("div0_lo", {32'b0, lo}, 64'h22);
    @(negedge clk);

    // Starts while busy are ignored
    issue(3'd0, 32'd5, 32'd7);
    issue(3'd5, 32'h55, 32'd0);
    issue(3'd0, 32'd2, 32'd2);
    wait_done("busy_ign", MUL_LAT - 2);
    check("busy_ign_lo", {32'b0, lo}, 64'd35);
    check("busy_ign_hi", {32'b0, hi}, 64'd0);

    // Signed boundaries
    issue(3'd0, 32'h80000000, 32'h80000000);
    wait_done("mult_min", MUL_LAT);
    check("mult_min_hi", {32'b0, hi}, 64'h40000000);
    check("mult_min_lo", {32'b0, lo}, 64'h0);
    issue(3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE);
    wait_done("div_nn", DIV_LAT);
    check("div_nn_lo", {32'b0, lo}, 64'd3);
    check("div_nn_hi", {32'b0, hi}, 64'hFFFFFFFF);

    // Reset in the 4th busy cycle aborts the divide
    issue(3'd2, 32'd100, 32'd7);          // now in busy cycle 1
    repeat (3) @(negedge clk);            // now in busy cycle 4
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dcount), 64'd0);

    // Overflow divide, then back-to-back start in the done cycle
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", DIV_LAT);
    check("div_ovf_lo", {32'b0, lo}, 64'h80000000);
    check("div_ovf_hi", {32'b0, hi}, 64'h0);
    issue(3'd1, 32'd3, 32'd4);
    check("b2b_busy", {63'b0, busy}, 64'd1);
    wait_done("b2b", MUL_LAT);
    check("b2b_lo", {32'b0, lo}, 64'd12);

    // Reset beats start; reserved op does nothing
    reset = 1'b1;
    issue(3'd4, 32'h99, 32'd0);
    reset = 1'b0;
    check("rst_start_hi", {32'b0, hi}, 64'd0);
    issue(3'd5, 32'h77, 32'd0);
    issue(3'd6, 32'h12, 32'h34);
    check("rsvd_busy", {63'b0, busy}, 64'd0);
    check("rsvd_lo", {32'b0, lo}, 64'h77);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
